// File: rtl/keypad_entry.sv
// Keypad number entry: collects up to four BCD digits, '*' clears, '#' commits via valid/ready.
// Optional binary output of the committed number when KEYPAD_ENTRY_BIN_EN is defined.
module keypad_entry #(
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [11:0] key_code,
  output logic        num_valid,
  input  logic        num_ready,
  output logic [15:0] num_bcd,
  output logic [15:0] disp_bcd,
  output logic [2:0]  digit_cnt,
  output logic        err
`ifdef KEYPAD_ENTRY_BIN_EN
  ,
  output logic [13:0] num_bin
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam bit TO_EN = (IDLE_TIMEOUT > 0);
  localparam int CW    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((IDLE_TIMEOUT > 0) ? (IDLE_TIMEOUT - 1) : 0);

  state_t          state_r;
  logic [CW-1:0]   idle_cnt_r;
  logic            key_onehot_s;
  logic            key_digit_s;
  logic            key_star_s;
  logic [3:0]      key_idx_s;
  logic            timeout_s;

  function automatic logic [13:0] bcd_to_bin(input logic [15:0] b);
    return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100
         + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
  endfunction

  // Key decode: one-hot check, class and digit value; timeout expiry detect
  always_comb begin
    key_onehot_s = (key_code != 12'd0) && ((key_code & (key_code - 12'd1)) == 12'd0);
    key_digit_s  = (key_code[9:0] != 10'd0);
    key_star_s   = key_code[10];
    key_idx_s    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      key_idx_s = key_idx_s | (key_code[i] ? 4'(i) : 4'd0);
    end
    timeout_s = TO_EN && (state_r == ST_ENTRY) && (idle_cnt_r == TO_LAST);
  end

  // Entry FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      idle_cnt_r <= '0;
      num_valid  <= 1'b0;
      num_bcd    <= 16'd0;
      disp_bcd   <= 16'd0;
      digit_cnt  <= 3'd0;
      err        <= 1'b0;
`ifdef KEYPAD_ENTRY_BIN_EN
      num_bin    <= 14'd0;
`endif
    end else begin
      err <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ENTRY: begin
          if (key_valid) begin
            if (!key_onehot_s) begin
              err <= 1'b1;
            end else if (key_digit_s) begin
              if (digit_cnt == 3'd4) begin
                err <= 1'b1;
              end else begin
                disp_bcd   <= {disp_bcd[11:0], key_idx_s};
                digit_cnt  <= digit_cnt + 3'd1;
                state_r    <= ST_ENTRY;
                idle_cnt_r <= '0;
              end
            end else if (key_star_s) begin
              disp_bcd   <= 16'd0;
              digit_cnt  <= 3'd0;
              state_r    <= ST_IDLE;
              idle_cnt_r <= '0;
            end else if (state_r == ST_IDLE) begin
              err <= 1'b1;
            end else begin
              num_bcd    <= disp_bcd;
`ifdef KEYPAD_ENTRY_BIN_EN
              num_bin    <= bcd_to_bin(disp_bcd);
`endif
              num_valid  <= 1'b1;
              disp_bcd   <= 16'd0;
              digit_cnt  <= 3'd0;
              state_r    <= ST_HOLD;
              idle_cnt_r <= '0;
            end
          end else if (timeout_s) begin
            disp_bcd   <= 16'd0;
            digit_cnt  <= 3'd0;
            state_r    <= ST_IDLE;
            idle_cnt_r <= '0;
          end else if (TO_EN && (state_r == ST_ENTRY)) begin
            idle_cnt_r <= idle_cnt_r + CW'(1);
          end else begin
            idle_cnt_r <= idle_cnt_r;
          end
        end
        ST_HOLD: begin
          // Every key is refused here, even one coinciding with the handshake
          err <= key_valid;
          if (num_valid && num_ready) begin
            num_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            num_valid <= num_valid;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          num_valid  <= 1'b0;
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: one instance with IDLE_TIMEOUT=8, one with the timeout disabled.
module tb_keypad_entry;

  localparam logic [11:0] K_STAR = 12'h400;
  localparam logic [11:0] K_HASH = 12'h800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [11:0] key_code = 12'd0;
  logic        num_ready = 1'b1;

  logic        num_valid, err, num_valid_nt, err_nt;
  logic [15:0] num_bcd, disp_bcd, num_bcd_nt, disp_bcd_nt;
  logic [2:0]  digit_cnt, digit_cnt_nt;
`ifdef KEYPAD_ENTRY_BIN_EN
  logic [13:0] num_bin, num_bin_nt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  keypad_entry #(.IDLE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .num_valid(num_valid), .num_ready(num_ready), .num_bcd(num_bcd),
    .disp_bcd(disp_bcd), .digit_cnt(digit_cnt), .err(err)
`ifdef KEYPAD_ENTRY_BIN_EN
    , .num_bin(num_bin)
`endif
  );

  keypad_entry dut_nt (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .num_valid(num_valid_nt), .num_ready(num_ready), .num_bcd(num_bcd_nt),
    .disp_bcd(disp_bcd_nt), .digit_cnt(digit_cnt_nt), .err(err_nt)
`ifdef KEYPAD_ENTRY_BIN_EN
    , .num_bin(num_bin_nt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; key is sampled on the next posedge; returns on the following negedge
  task automatic press(input logic [11:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 12'd0;
  endtask

  task automatic digit(input int d);
    logic [11:0] c;
    c = 12'd1 << d;
    press(c);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    wait_cyc(2);
    check("rst_valid", 32'(num_valid), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_bcd",   32'(num_bcd), 32'h0);
    check("rst_disp",  32'(disp_bcd), 32'h0);
    check("rst_cnt",   32'(digit_cnt), 32'd0);
    rst = 1'b1;
    wait_cyc(1);

    // 1,2,3,# with ready high
    digit(1); digit(2); digit(3);
    check("e123_disp", 32'(disp_bcd), 32'h0123);
    check("e123_cnt",  32'(digit_cnt), 32'd3);
    check("e123_err",  32'(err), 32'd0);
    press(K_HASH);
    check("c123_valid", 32'(num_valid), 32'd1);
    check("c123_bcd",   32'(num_bcd), 32'h0123);
    check("c123_disp",  32'(disp_bcd), 32'h0);
    check("c123_cnt",   32'(digit_cnt), 32'd0);
`ifdef KEYPAD_ENTRY_BIN_EN
    check("c123_bin",   32'(num_bin), 32'd123);
`endif
    wait_cyc(1);
    check("c123_drop",  32'(num_valid), 32'd0);
    check("c123_keep",  32'(num_bcd), 32'h0123);

    // 9,8,7,6,5: fifth digit rejected, then hold without ready
    digit(9); digit(8); digit(7); digit(6);
    check("e9876_cnt", 32'(digit_cnt), 32'd4);
    digit(5);
    check("ovf_err",  32'(err), 32'd1);
    check("ovf_disp", 32'(disp_bcd), 32'h9876);
    check("ovf_cnt",  32'(digit_cnt), 32'd4);
    wait_cyc(1);
    check("ovf_pulse", 32'(err), 32'd0);
    num_ready = 1'b0;
    press(K_HASH);
    check("c9876_valid", 32'(num_valid), 32'd1);
    check("c9876_bcd",   32'(num_bcd), 32'h9876);
`ifdef KEYPAD_ENTRY_BIN_EN
    check("c9876_bin",   32'(num_bin), 32'd9876);
`endif
    wait_cyc(10);
    check("hold_valid", 32'(num_valid), 32'd1);
    check("hold_bcd",   32'(num_bcd), 32'h9876);
    digit(1);
    check("hold_key_err",   32'(err), 32'd1);
    check("hold_key_valid", 32'(num_valid), 32'd1);
    num_ready = 1'b1;
    digit(2);
    check("hs_key_err",   32'(err), 32'd1);
    check("hs_valid",     32'(num_valid), 32'd0);
    check("hs_cnt",       32'(digit_cnt), 32'd0);
    check("hs_bcd",       32'(num_bcd), 32'h9876);
    wait_cyc(1);
    check("hs_err_pulse", 32'(err), 32'd0);

    // Malformed codes, ignored strobe-less code, '#' on empty buffer
    digit(2);
    press(12'h003);
    check("mh_err",  32'(err), 32'd1);
    check("mh_cnt",  32'(digit_cnt), 32'd1);
    check("mh_disp", 32'(disp_bcd), 32'h0002);
    press(12'h000);
    check("zero_err", 32'(err), 32'd1);
    key_code = 12'h010;
    wait_cyc(1);
    key_code = 12'd0;
    check("nostrobe_cnt", 32'(digit_cnt), 32'd1);
    check("nostrobe_err", 32'(err), 32'd0);
    press(K_STAR);
    press(K_HASH);
    check("empty_hash_err",   32'(err), 32'd1);
    check("empty_hash_valid", 32'(num_valid), 32'd0);

    // 4,5,* clears without error
    wait_cyc(1);
    digit(4); digit(5);
    press(K_STAR);
    check("star_disp", 32'(disp_bcd), 32'h0);
    check("star_cnt",  32'(digit_cnt), 32'd0);
    check("star_err",  32'(err), 32'd0);
    press(K_HASH);
    check("star_idle", 32'(err), 32'd1);

    // Idle timeout: expiry after 8 idle cycles; key on the expiry cycle is kept
    wait_cyc(1);
    digit(7);
    wait_cyc(7);
    check("to_before",    32'(digit_cnt), 32'd1);
    wait_cyc(1);
    check("to_cleared",   32'(digit_cnt), 32'd0);
    check("to_disp",      32'(disp_bcd), 32'h0);
    check("nt_kept",      32'(digit_cnt_nt), 32'd1);
    check("nt_disp",      32'(disp_bcd_nt), 32'h0007);
    press(K_STAR);
    digit(7);
    wait_cyc(7);
    digit(3);
    check("to_race_disp", 32'(disp_bcd), 32'h0073);
    check("to_race_cnt",  32'(digit_cnt), 32'd2);
    wait_cyc(7);
    check("to_reload",    32'(digit_cnt), 32'd2);
    wait_cyc(1);
    check("to_race_clr",  32'(digit_cnt), 32'd0);
    press(K_STAR);

    // Reset during HOLD discards the pending number
    num_ready = 1'b0;
    digit(5);
    press(K_HASH);
    check("pre_rst_valid", 32'(num_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_hold_valid", 32'(num_valid), 32'd0);
    check("rst_hold_bcd",   32'(num_bcd), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    num_ready = 1'b1;
    wait_cyc(1);
    digit(1);
    press(K_HASH);
    check("post_rst_valid", 32'(num_valid), 32'd1);
    check("post_rst_bcd",   32'(num_bcd), 32'h0001);
`ifdef KEYPAD_ENTRY_BIN_EN
    check("post_rst_bin",   32'(num_bin), 32'd1);
`endif
    wait_cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 0, the number of cycles without a key in ENTRY before auto-clear; 0 disables the timeout.
REQ-002 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have key_valid  input  1  one-cycle key strobe from the scanner.
REQ-005 SHALL have key_code  input  12  one-hot key: bits 0-9 = digits 0-9, bit 10 = '*', bit 11 = '#'.
REQ-006 SHALL have num_valid  output  1  committed number available.
REQ-007 SHALL have num_ready  input  1  consumer accepts the number.
REQ-008 SHALL have num_bcd  output  16  committed number, 4 BCD digits, right-justified.
REQ-009 SHALL have disp_bcd  output  16  live entry buffer, 4 BCD digits.
REQ-010 SHALL have digit_cnt  output  3  digits currently in the buffer (0-4).
REQ-011 SHALL have err  output  1  one-cycle pulse on a rejected key.

Function
REQ-012 SHALL implement the states IDLE (0 digits), ENTRY (1-4 digits) and HOLD (number committed, awaiting the handshake).
REQ-013 SHALL sample key_code only in a cycle where key_valid=1; key_code is ignored otherwise.
REQ-014 SHALL treat a key_code that is not exactly one-hot (zero or multiple bits set) as rejected: state unchanged, err=1 on the next cycle.
REQ-015 SHALL, on a digit d in IDLE/ENTRY with digit_cnt<4, load disp_bcd <= {disp_bcd[11:0], d} and increment digit_cnt on the next edge; IDLE moves to ENTRY.
REQ-016 SHALL, on a digit with digit_cnt=4, reject the key: buffer unchanged, err pulse.
REQ-017 SHALL, on '*' in IDLE/ENTRY, clear disp_bcd and digit_cnt to 0 and go to IDLE; no err.
REQ-018 SHALL, on '#' in ENTRY, copy disp_bcd to num_bcd, clear disp_bcd and digit_cnt, go to HOLD, and assert num_valid on the cycle after the '#' strobe.
REQ-019 SHALL, on '#' in IDLE (empty buffer), reject the key with an err pulse and make no commit.
REQ-020 SHALL hold num_valid and num_bcd stable in HOLD until num_valid&num_ready; num_valid deasserts on the next edge and the state goes to IDLE.
REQ-021 SHALL reject any key arriving in HOLD with an err pulse, including a key in the same cycle as the completing handshake.
REQ-022 SHALL, when IDLE_TIMEOUT>0, reload the idle counter on every accepted key and count in ENTRY; on reaching IDLE_TIMEOUT it clears the buffer and goes to IDLE.
REQ-023 SHALL give an accepted key priority over a simultaneous timeout expiry: the key is applied and the counter reloaded.
REQ-024 SHALL keep err a single-cycle registered pulse; num_bcd holds its last value outside HOLD.

Reset
REQ-025 SHALL, on rst=0, immediately go to IDLE with num_valid=0, err=0, num_bcd=0, disp_bcd=0, digit_cnt=0 and the idle counter at 0, regardless of the current state.
REQ-026 SHALL, on reset during HOLD, discard the pending number; no transfer occurs.

Configuration
REQ-027 SHALL, when macro KEYPAD_ENTRY_BIN_EN is defined, add output num_bin (14 bits), the binary value of num_bcd (0-9999), registered and valid in the same cycle as num_valid.
REQ-028 SHALL, without KEYPAD_ENTRY_BIN_EN, omit the num_bin port and its logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: keys 1,2,3,'#' (num_ready=1) -> num_valid for 1 cycle, num_bcd=16'h0123, with KEYPAD_ENTRY_BIN_EN num_bin=123.
REQ-030 SHALL cover: keys 9,8,7,6,5 -> 5th key gives an err pulse, disp_bcd=16'h9876; then '#' with num_ready=0 for 10 cycles -> num_valid held and num_bcd stable until num_ready=1.
REQ-031 SHALL cover: key_code=12'h003 with key_valid=1 -> err pulse, digit_cnt unchanged; '#' on an empty buffer -> err, no num_valid.
REQ-032 SHALL cover: keys 4,5,'*' -> disp_bcd=0, digit_cnt=0, state IDLE, no err.
REQ-033 SHALL cover: IDLE_TIMEOUT=8, key 7 then 8 idle cycles -> buffer clears; a key in the expiry cycle is kept instead.
REQ-034 SHALL cover: rst pulsed low in HOLD -> num_valid=0 immediately, next keys 1,'#' -> num_bcd=16'h0001.
